// File: rtl/gen1_byteport_pkg.sv
// Shared definitions for the gen1 byte port: FSM states, fault causes,
// the DEV window base and the timer width.
package gen1_byteport_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SRAM_ACC,
      ST_DEV_ACC,
      ST_ACK,
      ST_GAP,
      ST_FAULT,
      ST_FAULT_REL
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_TIMEOUT  = 2'd0,
      CAUSE_UNMAPPED = 2'd1,
      CAUSE_EXEC_DEV = 2'd2,
      CAUSE_PROTOCOL = 2'd3
   } cause_t;

   localparam logic [31:0] DEV_BASE = 32'hFFFF_0000;

   // Wide enough for the largest DEV timeout (1023).
   localparam int TIMER_W = 10;

   function automatic logic in_dev_window(input logic [31:0] addr);
      return addr[31:16] == DEV_BASE[31:16];
   endfunction

endpackage

// File: rtl/gen1_byteport_timer.sv
// Loadable down-counter shared by the SRAM wait, DEV timeout and gap phases;
// it saturates at zero.
module gen1_byteport_timer
   import gen1_byteport_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] value,
   input  logic               dec,
   output logic               zero
);

   logic [TIMER_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (dec && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/gen1_byteport.sv
// Byte-wide bus port: decodes upstream byte requests onto an SRAM window or
// a 16-bit device window, paces completions and raises bus exceptions.
module gen1_byteport
   import gen1_byteport_pkg::*;
#(
   parameter int SRAM_AW     = 20,
   parameter int SRAM_WAIT   = 1,
   parameter int DEV_TIMEOUT = 255,
   parameter int GAP_CYCLES  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        xaddr,
   input  logic [7:0]         xdout,
   output logic [7:0]         xdin,
   input  logic               memread,
   input  logic               memwrite,
   input  logic               memexec,
   output logic               memready,
   output logic               busx,
   input  logic               busxa,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [7:0]         sram_wdata,
   input  logic [7:0]         sram_rdata,
   output logic               sram_ce,
   output logic               sram_oe,
   output logic               sram_we,
   output logic [15:0]        dev_addr,
   output logic [7:0]         dev_wdata,
   input  logic [7:0]         dev_rdata,
   output logic               dev_rd,
   output logic               dev_wr,
   input  logic               dev_ready,
   output logic [31:0]        fault_addr,
   output logic [1:0]         fault_cause
);

   state_t             state, next_state;
   logic [31:0]        addr_q;
   logic [7:0]         wdata_q;
   logic               write_q;

   logic               req, sel_sram, sel_dev, req_fault;
   cause_t             req_cause;
   logic               capture;
   logic [7:0]         capture_data;

   logic               timer_load, timer_dec, timer_zero;
   logic [TIMER_W-1:0] timer_value;

   gen1_byteport_timer u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .value (timer_value),
      .dec   (timer_dec),
      .zero  (timer_zero)
   );

   assign req      = memread | memwrite;
   assign sel_sram = (xaddr >> SRAM_AW) == '0;
   assign sel_dev  = in_dev_window(xaddr);

   // Both directions at once outranks any decode-based fault.
   always_comb begin
      req_fault = 1'b1;
      req_cause = CAUSE_PROTOCOL;
      if (memread && memwrite) begin
         req_cause = CAUSE_PROTOCOL;
      end else if (!sel_sram && !sel_dev) begin
         req_cause = CAUSE_UNMAPPED;
      end else if (sel_dev && memexec) begin
         req_cause = CAUSE_EXEC_DEV;
      end else begin
         req_fault = 1'b0;
      end
   end

   assign capture_data = (state == ST_SRAM_ACC) ? sram_rdata : dev_rdata;
   assign sram_addr    = addr_q[SRAM_AW-1:0];
   assign dev_addr     = addr_q[15:0];
   assign sram_wdata   = wdata_q;
   assign dev_wdata    = wdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         xdin        <= '0;
         memready    <= 1'b0;
         fault_addr  <= '0;
         fault_cause <= CAUSE_TIMEOUT;
      end else begin
         state    <= next_state;
         // The completion pulse follows the ACK cycle by one edge.
         memready <= (state == ST_ACK);
         if (state == ST_IDLE && req) begin
            if (req_fault) begin
               fault_addr  <= xaddr;
               fault_cause <= req_cause;
            end else begin
               addr_q  <= xaddr;
               wdata_q <= xdout;
               write_q <= memwrite;
            end
         end
         if (state == ST_DEV_ACC && next_state == ST_FAULT) begin
            fault_addr  <= addr_q;
            fault_cause <= CAUSE_TIMEOUT;
         end
         if (capture) begin
            xdin <= capture_data;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      next_state  = state;
      timer_load  = 1'b0;
      timer_value = '0;
      timer_dec   = 1'b0;
      capture     = 1'b0;
      sram_ce     = 1'b0;
      sram_oe     = 1'b0;
      sram_we     = 1'b0;
      dev_rd      = 1'b0;
      dev_wr      = 1'b0;
      busx        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (req_fault) begin
                  next_state = ST_FAULT;
               end else if (sel_sram) begin
                  next_state  = ST_SRAM_ACC;
                  timer_load  = 1'b1;
                  timer_value = TIMER_W'(SRAM_WAIT);
               end else begin
                  next_state  = ST_DEV_ACC;
                  timer_load  = 1'b1;
                  timer_value = TIMER_W'(DEV_TIMEOUT);
               end
            end
         end
         ST_SRAM_ACC: begin
            sram_ce = 1'b1;
            sram_oe = !write_q;
            sram_we = write_q;
            if (timer_zero) begin
               capture    = !write_q;
               next_state = ST_ACK;
            end else begin
               timer_dec = 1'b1;
            end
         end
         ST_DEV_ACC: begin
            dev_rd = !write_q;
            dev_wr = write_q;
            if (dev_ready) begin
               capture    = !write_q;
               next_state = ST_ACK;
            end else if (timer_zero) begin
               next_state = ST_FAULT;
            end else begin
               timer_dec = 1'b1;
            end
         end
         ST_ACK: begin
            next_state  = ST_GAP;
            timer_load  = 1'b1;
            timer_value = TIMER_W'(GAP_CYCLES - 1);
         end
         ST_GAP: begin
            if (timer_zero) begin
               next_state = ST_IDLE;
            end else begin
               timer_dec = 1'b1;
            end
         end
         ST_FAULT: begin
            busx = 1'b1;
            if (busxa) begin
               next_state = ST_FAULT_REL;
            end
         end
         ST_FAULT_REL: begin
            if (!busxa) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_gen1_byteport.sv
// Self-checking bench for gen1_byteport: directed vector table, randomized
// accesses against a behavioural model, held-write and mid-access reset.
module tb_gen1_byteport;

   localparam int SRAM_AW     = 20;
   localparam int SRAM_WAIT   = 1;
   localparam int DEV_TIMEOUT = 8;
   localparam int GAP_CYCLES  = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [31:0]        xaddr = '0;
   logic [7:0]         xdout = '0;
   logic [7:0]         xdin;
   logic               memread = 1'b0, memwrite = 1'b0, memexec = 1'b0;
   logic               memready, busx;
   logic               busxa = 1'b0;
   logic [SRAM_AW-1:0] sram_addr;
   logic [7:0]         sram_wdata, sram_rdata;
   logic               sram_ce, sram_oe, sram_we;
   logic [15:0]        dev_addr;
   logic [7:0]         dev_wdata;
   logic [7:0]         dev_rdata = '0;
   logic               dev_rd, dev_wr;
   logic               dev_ready = 1'b0;
   logic [31:0]        fault_addr;
   logic [1:0]         fault_cause;

   gen1_byteport #(
      .SRAM_AW(SRAM_AW), .SRAM_WAIT(SRAM_WAIT),
      .DEV_TIMEOUT(DEV_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .xaddr(xaddr), .xdout(xdout), .xdin(xdin),
      .memread(memread), .memwrite(memwrite), .memexec(memexec),
      .memready(memready), .busx(busx), .busxa(busxa),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we),
      .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
      .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_ready(dev_ready),
      .fault_addr(fault_addr), .fault_cause(fault_cause)
   );

   always #5 clk = ~clk;

   // SRAM device: low 8 KiB backing store, cleared (with 0x10 = 0x5A) on reset.
   logic [7:0] sram_env [0:8191];
   assign sram_rdata = sram_env[sram_addr[12:0]];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8192; i++) sram_env[i] <= (i == 16) ? 8'h5A : 8'h00;
      end else if (sram_ce && sram_we) begin
         sram_env[sram_addr[12:0]] <= sram_wdata;
      end
   end

   typedef struct {
      logic [31:0] addr;
      bit          rd, wr, ex;
      logic [7:0]  wdata, rdata;
      int          dly;     // cycle count of dev strobe before dev_ready; 0 = never
   } stim_t;

   typedef struct {
      bit          fault;
      logic [1:0]  cause;
      int          k;       // cycle index of memready (success) or busx (fault)
      int          strobes;
      logic [7:0]  xdin;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   typedef struct {
      int mr_k, mr_count, busx_k, rd_cnt, wr_cnt;
      bit overlap, busx_rel;
   } obs_t;

   int total = 0;
   int bad   = 0;

   logic [7:0]  shadow [logic [31:0]];
   logic [7:0]  model_xdin  = '0;
   logic [31:0] exp_faddr   = '0;
   logic [1:0]  exp_cause   = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_sram(input logic [31:0] a);
      return {1'b0, a} < (33'd1 << SRAM_AW);
   endfunction

   function automatic logic [7:0] shadow_read(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : 8'h00;
   endfunction

   // Reference model: outcome of one access from the decode and timing rules.
   function automatic exp_t predict(input stim_t s);
      exp_t e;
      bit   in_dev;
      in_dev = (s.addr >= 32'hFFFF_0000);
      e = '{fault: 1'b0, cause: 2'd0, k: 0, strobes: 0, xdin: model_xdin};
      if (s.rd && s.wr) begin
         e.fault = 1'b1; e.cause = 2'd3;
      end else if (!is_sram(s.addr) && !in_dev) begin
         e.fault = 1'b1; e.cause = 2'd1;
      end else if (in_dev && s.ex) begin
         e.fault = 1'b1; e.cause = 2'd2;
      end else if (is_sram(s.addr)) begin
         e.k = SRAM_WAIT + 2; e.strobes = SRAM_WAIT + 1;
         if (s.rd) e.xdin = shadow_read(s.addr);
      end else if (s.dly >= 1 && s.dly <= DEV_TIMEOUT + 1) begin
         e.k = s.dly + 1; e.strobes = s.dly;
         if (s.rd) e.xdin = s.rdata;
      end else begin
         e.fault = 1'b1; e.cause = 2'd0;
         e.k = DEV_TIMEOUT + 1; e.strobes = DEV_TIMEOUT + 1;
      end
      return e;
   endfunction

   task automatic run_access(input stim_t s, output obs_t o);
      o = '{mr_k: -1, mr_count: 0, busx_k: -1, rd_cnt: 0, wr_cnt: 0, overlap: 1'b0, busx_rel: 1'b1};
      @(negedge clk);
      xaddr = s.addr; xdout = s.wdata; memread = s.rd; memwrite = s.wr; memexec = s.ex;
      dev_rdata = s.rdata; dev_ready = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) begin memread = 1'b0; memwrite = 1'b0; memexec = 1'b0; end
         if (sram_oe || dev_rd) o.rd_cnt++;
         if (sram_we || dev_wr) o.wr_cnt++;
         if ((sram_oe && sram_we) || (dev_rd && dev_wr) || ((sram_oe || sram_we) && !sram_ce)
             || ((sram_ce || sram_oe || sram_we) && (dev_rd || dev_wr))) o.overlap = 1'b1;
         if (memready) begin
            if (o.mr_k < 0) o.mr_k = k;
            o.mr_count++;
         end
         if (busx && o.busx_k < 0) o.busx_k = k;
         dev_ready = (s.dly > 0) && (k == s.dly - 1);
         if (o.busx_k >= 0) begin
            dev_ready = 1'b0;
            busxa = 1'b1;
            @(negedge clk);
            o.busx_rel = busx;
            busxa = 1'b0;
            @(negedge clk);
            break;
         end
         if (o.mr_k >= 0 && k == o.mr_k + GAP_CYCLES - 1) break;
      end
      dev_ready = 1'b0;
   endtask

   task automatic check_access(input string tag, input stim_t s, input exp_t e);
      obs_t o;
      run_access(s, o);
      if (e.fault) begin
         exp_faddr = s.addr;
         exp_cause = e.cause;
         check($sformatf("%s busx_cycle", tag), o.busx_k, e.k);
         check($sformatf("%s busx_after_ack", tag), o.busx_rel, 0);
         check($sformatf("%s memready_count", tag), o.mr_count, 0);
      end else begin
         check($sformatf("%s memready_cycle", tag), o.mr_k, e.k);
         check($sformatf("%s memready_count", tag), o.mr_count, 1);
         check($sformatf("%s busx_cycle", tag), o.busx_k, -1);
      end
      check($sformatf("%s read_strobes", tag), o.rd_cnt, (s.rd && !s.wr) ? e.strobes : 0);
      check($sformatf("%s write_strobes", tag), o.wr_cnt, (s.wr && !s.rd) ? e.strobes : 0);
      check($sformatf("%s strobe_overlap", tag), o.overlap, 0);
      check($sformatf("%s xdin", tag), xdin, e.xdin);
      check($sformatf("%s fault_addr", tag), fault_addr, exp_faddr);
      check($sformatf("%s fault_cause", tag), fault_cause, exp_cause);
      model_xdin = e.xdin;
      if (!e.fault && s.wr && is_sram(s.addr)) shadow[s.addr] = s.wdata;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t       tbl [14];
      stim_t      s;
      exp_t       e;
      logic [7:0] wbytes [4];
      int         bursts, pulses, last_c, min_gap, extra;
      bit         prev_we;

      //           addr           rd wr ex wdata  rdata  dly    fault cause k  str xdin
      tbl[0]  = '{'{32'h0000_0010, 1, 0, 0, 8'h00, 8'h00, 0},  '{0, 2'd0, 3,  2, 8'h5A}};
      tbl[1]  = '{'{32'h000F_FFFF, 0, 1, 0, 8'hC3, 8'h00, 0},  '{0, 2'd0, 3,  2, 8'h5A}};
      tbl[2]  = '{'{32'h000F_FFFF, 1, 0, 0, 8'h00, 8'h00, 0},  '{0, 2'd0, 3,  2, 8'hC3}};
      tbl[3]  = '{'{32'hFFFF_0004, 1, 0, 0, 8'h00, 8'hA5, 5},  '{0, 2'd0, 6,  5, 8'hA5}};
      tbl[4]  = '{'{32'hFFFF_0004, 1, 0, 0, 8'h00, 8'h3C, 9},  '{0, 2'd0, 10, 9, 8'h3C}};
      tbl[5]  = '{'{32'hFFFF_0004, 1, 0, 0, 8'h00, 8'h77, 0},  '{1, 2'd0, 9,  9, 8'h3C}};
      tbl[6]  = '{'{32'hFFFF_00FF, 0, 1, 0, 8'h99, 8'h00, 1},  '{0, 2'd0, 2,  1, 8'h3C}};
      tbl[7]  = '{'{32'hFFFF_0000, 1, 0, 1, 8'h00, 8'h00, 1},  '{1, 2'd2, 0,  0, 8'h3C}};
      tbl[8]  = '{'{32'h8000_0000, 1, 0, 0, 8'h00, 8'h00, 0},  '{1, 2'd1, 0,  0, 8'h3C}};
      tbl[9]  = '{'{32'h0010_0000, 1, 0, 0, 8'h00, 8'h00, 0},  '{1, 2'd1, 0,  0, 8'h3C}};
      tbl[10] = '{'{32'h0000_0010, 1, 1, 0, 8'h00, 8'h00, 0},  '{1, 2'd3, 0,  0, 8'h3C}};
      tbl[11] = '{'{32'h8000_0000, 1, 1, 1, 8'h00, 8'h00, 0},  '{1, 2'd3, 0,  0, 8'h3C}};
      tbl[12] = '{'{32'h0000_0010, 1, 0, 1, 8'h00, 8'h00, 0},  '{0, 2'd0, 3,  2, 8'h5A}};
      tbl[13] = '{'{32'hFFFF_1234, 1, 0, 0, 8'h00, 8'h11, 10}, '{1, 2'd0, 9,  9, 8'h5A}};

      shadow[32'h10] = 8'h5A;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset strobes", {sram_ce, sram_oe, sram_we, dev_rd, dev_wr, memready, busx}, 0);
      check("reset xdin", xdin, 0);
      check("reset sram_addr", sram_addr, 0);
      check("reset dev_addr_wdata", {dev_addr, dev_wdata, sram_wdata}, 0);
      check("reset fault", {fault_addr, fault_cause}, 0);

      for (int i = 0; i < 14; i++) begin
         check_access($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);
      end

      for (int i = 0; i < 40; i++) begin
         int region;
         region = $urandom_range(0, 9);
         s.wdata = 8'($urandom);
         s.rdata = 8'($urandom);
         s.dly   = $urandom_range(0, 10);
         s.rd    = $urandom_range(0, 1);
         s.wr    = !s.rd;
         if ($urandom_range(0, 15) == 0) begin s.rd = 1'b1; s.wr = 1'b1; end
         s.ex    = s.rd && ($urandom_range(0, 7) == 0);
         if (region < 5)       s.addr = 32'h1000 + $urandom_range(0, 32'hEFF);
         else if (region < 8)  s.addr = 32'hFFFF_0000 | 32'($urandom_range(0, 32'hFFFF));
         else if (region == 8) s.addr = 32'h0010_0000 + $urandom_range(0, 32'h7FFF_0000);
         else                  s.addr = 32'h1000 + $urandom_range(0, 15);
         e = predict(s);
         check_access($sformatf("rnd%0d", i), s, e);
      end

      // Held memwrite: four bytes, address advanced after each memready.
      wbytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      bursts = 0; pulses = 0; last_c = 0; min_gap = 1000; prev_we = 1'b0;
      @(negedge clk);
      xaddr = 32'h100; xdout = wbytes[0]; memwrite = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (sram_we && !prev_we) bursts++;
         prev_we = sram_we;
         if (memready) begin
            if (pulses > 0 && c - last_c < min_gap) min_gap = c - last_c;
            last_c = c;
            pulses++;
            if (pulses < 4) begin
               xaddr = 32'h100 + 32'(pulses);
               xdout = wbytes[pulses];
            end else begin
               memwrite = 1'b0;
            end
         end
      end
      check("held we_bursts", bursts, 4);
      check("held memready_pulses", pulses, 4);
      check("held pulse_spacing_ok", min_gap >= GAP_CYCLES + 1, 1);
      check("held sram_word",
            {sram_env[13'h103], sram_env[13'h102], sram_env[13'h101], sram_env[13'h100]},
            32'h4433_2211);
      for (int b = 0; b < 4; b++) shadow[32'h100 + 32'(b)] = wbytes[b];

      // Reset during an SRAM write aborts it.
      @(negedge clk);
      xaddr = 32'h200; xdout = 8'h77; memwrite = 1'b1;
      @(negedge clk);
      memwrite = 1'b0;
      check("rstmid we_active", sram_we, 1);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid strobes_after", {sram_ce, sram_we, memready, busx}, 0);
      reset = 1'b0;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (memready || busx || sram_ce || sram_we || dev_rd || dev_wr) extra++;
      end
      check("rstmid no_activity", extra, 0);
      check("rstmid xdin", xdin, 0);
      check("rstmid fault", {fault_addr, fault_cause}, 0);
      shadow.delete();
      shadow[32'h10] = 8'h5A;
      model_xdin = 8'h00; exp_faddr = '0; exp_cause = '0;
      s = '{addr: 32'h10, rd: 1'b1, wr: 1'b0, ex: 1'b0, wdata: 8'h00, rdata: 8'h00, dly: 0};
      check_access("post_reset_read", s, predict(s));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
